// File: rtl/activation_writeback.sv
// Activation write-back: buffers commit-stage words in a small FIFO and streams them to the
// activation bank over a req/gnt port, one word per transfer at consecutive addresses.
module activation_writeback #(
  parameter int unsigned ACTIVATION_BANK_BIT_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH                = 16,
  parameter int unsigned FIFO_DEPTH                = 4
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 i_start,
  input  logic [ADDR_WIDTH-1:0]                i_base_addr,
  input  logic                                 i_valid,
  input  logic [ACTIVATION_BANK_BIT_WIDTH-1:0] i_data,
  input  logic                                 i_last,
  output logic                                 o_mem_req,
  input  logic                                 i_mem_gnt,
  output logic [ADDR_WIDTH-1:0]                o_mem_addr,
  output logic [ACTIVATION_BANK_BIT_WIDTH-1:0] o_mem_wdata,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic [ADDR_WIDTH-1:0]                o_word_count,
  output logic                                 o_overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e r_state;
  state_e w_state_next;

  logic [ACTIVATION_BANK_BIT_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]                r_fifo_last;
  // One extra pointer bit distinguishes full from empty.
  logic [PtrW:0]                        r_wr_ptr;
  logic [PtrW:0]                        r_rd_ptr;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_count;
  logic                  r_overflow;

  logic                                 w_empty;
  logic                                 w_full;
  logic                                 w_req;
  logic                                 w_pop;
  logic                                 w_push;
  logic                                 w_drop;
  logic                                 w_start;
  logic                                 w_head_last;
  logic [ACTIVATION_BANK_BIT_WIDTH-1:0] w_head_data;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[PtrW] != r_rd_ptr[PtrW]) &&
                       (r_wr_ptr[PtrW-1:0] == r_rd_ptr[PtrW-1:0]);
  assign w_head_data = r_fifo_data[r_rd_ptr[PtrW-1:0]];
  assign w_head_last = r_fifo_last[r_rd_ptr[PtrW-1:0]];

  assign w_req   = (r_state == StRun) && !w_empty;
  assign w_pop   = w_req && i_mem_gnt;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_push  = i_valid && (!w_full || w_pop);
  assign w_drop  = i_valid && w_full && !w_pop;
  assign w_start = (r_state == StIdle) && i_start;

  // Storage needs no reset: pointers define validity and the write data is gated by w_req.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr[PtrW-1:0]] <= i_data;
      r_fifo_last[r_wr_ptr[PtrW-1:0]] <= i_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (PtrW + 1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_addr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr  <= i_base_addr;
        r_count <= '0;
      end else if (w_pop) begin
        r_addr  <= r_addr + ADDR_WIDTH'(1);
        r_count <= r_count + ADDR_WIDTH'(1);
      end
      // A drop in the same cycle as start is still reported.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_start) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StRun;
      StRun:   if (w_pop && w_head_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_mem_req    = w_req;
    o_mem_addr   = r_addr;
    o_mem_wdata  = w_req ? w_head_data : '0;
    o_busy       = (r_state == StRun);
    o_done       = (r_state == StDone);
    o_word_count = r_count;
    o_overflow   = r_overflow;
  end

endmodule
